// File: rtl/operand_arbiter.sv
// Round-robin arbiter that shares one operand mux between two requesters and
// holds the selected operand in a one-entry output register with valid/ready.
module operand_arbiter #(
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic             ack0,
   output logic             ack1,
   output logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             owner
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   state_t     state;
   logic [3:0] cnt;
   logic       rr;

   logic       slot_free;
   logic       cap0;
   logic       cap1;
   logic       capture;
   logic       own_req;
   logic       other_req;
   logic [3:0] cnt_inc;

   // The slot is free when empty or when the current operand leaves this cycle.
   assign slot_free = !y_valid || y_ready;
   assign cap0      = !rst && (state == OWN0) && req0 && slot_free;
   assign cap1      = !rst && (state == OWN1) && req1 && slot_free;
   assign capture   = cap0 || cap1;
   assign ack0      = cap0;
   assign ack1      = cap1;
   assign own_req   = (state == OWN1) ? req1 : req0;
   assign other_req = (state == OWN1) ? req0 : req1;
   assign cnt_inc   = cnt + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= 1'b0;
         y       <= '0;
         y_valid <= 1'b0;
         owner   <= 1'b0;
         cnt     <= 4'd0;
         rr      <= 1'b0;
      end else begin
         if (capture) begin
            y       <= cap1 ? i1 : i0;
            owner   <= cap1;
            y_valid <= 1'b1;
         end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               // On a tie rr decides; sel only moves when a grant is made.
               if (req0 && (!req1 || !rr)) begin
                  state <= OWN0;
                  sel   <= 1'b0;
               end else if (req1) begin
                  state <= OWN1;
                  sel   <= 1'b1;
               end
            end
            OWN0, OWN1: begin
               if (!own_req) begin
                  cnt <= 4'd0;
                  if (other_req) begin
                     state <= (state == OWN0) ? OWN1 : OWN0;
                     sel   <= (state == OWN0);
                     rr    <= (state == OWN0);
                  end else begin
                     state <= IDLE;
                  end
               end else if (capture && (cnt_inc == BURST_LIMIT)) begin
                  // Burst exhausted: hand over only if the other side waits.
                  cnt <= 4'd0;
                  if (other_req) begin
                     state <= (state == OWN0) ? OWN1 : OWN0;
                     sel   <= (state == OWN0);
                     rr    <= (state == OWN0);
                  end
               end else if (capture) begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_arbiter.sv
// Self-checking bench for operand_arbiter: a cycle-level reference model checked
// on every falling edge, plus directed scenarios with hand-computed expectations.
module tb_operand_arbiter;

   localparam int W  = 4;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0;
   logic         req1;
   logic [W-1:0] i0;
   logic [W-1:0] i1;
   logic         ack0;
   logic         ack1;
   logic         sel;
   logic [W-1:0] y;
   logic         y_valid;
   logic         y_ready;
   logic         owner;

   int checks = 0;
   int errors = 0;

   operand_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .i0     (i0),
      .i1     (i1),
      .ack0   (ack0),
      .ack1   (ack1),
      .sel    (sel),
      .y      (y),
      .y_valid(y_valid),
      .y_ready(y_ready),
      .owner  (owner)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic r1, input logic [W-1:0] d0,
                                input logic [W-1:0] d1, input logic rdy);
      req0    = r0;
      req1    = r1;
      i0      = d0;
      i1      = d1;
      y_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reference model: grant is -1 when nobody holds the mux, else the owner index.
   int           m_grant;
   int           m_sel;
   int           m_owner;
   int           m_burst;
   int           m_favour;
   int           took;
   int           other;
   logic [W-1:0] m_y;
   logic         m_valid;
   logic         rq[2];
   logic [W-1:0] dd[2];

   task automatic modelReset();
      m_grant  = -1;
      m_sel    = 0;
      m_owner  = 0;
      m_burst  = 0;
      m_favour = 0;
      m_y      = '0;
      m_valid  = 1'b0;
   endtask

   initial begin
      modelReset();
      forever begin
         @(negedge clk);
         rq[0] = req0;
         rq[1] = req1;
         dd[0] = i0;
         dd[1] = i1;
         if (rst) begin
            modelReset();
            took = -1;
         end else begin
            took = -1;
            if (m_grant >= 0 && rq[m_grant] && (!m_valid || y_ready)) took = m_grant;
         end
         checkOutput("model_ack0", ack0, (took == 0));
         checkOutput("model_ack1", ack1, (took == 1));
         checkOutput("model_sel", sel, m_sel);
         checkOutput("model_y", y, m_y);
         checkOutput("model_y_valid", y_valid, m_valid);
         checkOutput("model_owner", owner, m_owner);
         if (!rst) begin
            if (m_valid && y_ready) m_valid = 1'b0;
            if (took >= 0) begin
               m_y     = dd[took];
               m_owner = took;
               m_valid = 1'b1;
               m_burst++;
            end
            if (m_grant < 0) begin
               if (rq[0] || rq[1]) begin
                  m_grant = (rq[0] && rq[1]) ? m_favour : (rq[0] ? 0 : 1);
                  m_sel   = m_grant;
               end
            end else begin
               other = 1 - m_grant;
               if (!rq[m_grant]) begin
                  m_burst = 0;
                  if (rq[other]) begin
                     m_grant  = other;
                     m_favour = other;
                     m_sel    = other;
                  end else begin
                     m_grant = -1;
                  end
               end else if (m_burst == MB) begin
                  m_burst = 0;
                  if (rq[other]) begin
                     m_grant  = other;
                     m_favour = other;
                     m_sel    = other;
                  end
               end
            end
         end
      end
   end

   logic a0[13];
   logic a1[13];
   logic ow[13];
   int   ack_count;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      @(negedge clk);
      checkOutput("reset_y_valid", y_valid, 0);
      checkOutput("reset_y", y, 0);
      checkOutput("reset_sel", sel, 0);
      checkOutput("reset_owner", owner, 0);
      tick();
      rst = 1'b0;

      // Single requester
      applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("single_n_ack0", ack0, 0);
      tick();
      @(negedge clk);
      checkOutput("single_n1_sel", sel, 0);
      checkOutput("single_n1_ack0", ack0, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h5, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("single_n2_y", y, 5);
      checkOutput("single_n2_owner", owner, 0);
      checkOutput("single_n2_y_valid", y_valid, 1);
      tick();
      @(negedge clk);
      checkOutput("single_drain_y_valid", y_valid, 0);

      // Round-robin tie from idle
      doReset();
      applyStimulus(1'b1, 1'b1, 4'h3, 4'hA, 1'b1);
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         a0[k] = ack0;
         a1[k] = ack1;
         ow[k] = owner;
         if (k == 6) checkOutput("rr_y_from_1", y, 4'hA);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 4'h3, 4'hA, 1'b1);
      for (int k = 0; k < 13; k++) begin
         checkOutput($sformatf("rr_ack0_c%0d", k), a0[k], ((k >= 1 && k <= 4) || (k >= 9)));
         checkOutput($sformatf("rr_ack1_c%0d", k), a1[k], (k >= 5 && k <= 8));
         if (k >= 2) checkOutput($sformatf("rr_owner_c%0d", k), ow[k], (k >= 6 && k <= 9));
      end

      // Backpressure while OWN1
      doReset();
      applyStimulus(1'b0, 1'b1, 4'h0, 4'h7, 1'b1);
      @(negedge clk);
      checkOutput("bp_c0_ack1", ack1, 0);
      tick();
      @(negedge clk);
      checkOutput("bp_c1_ack1", ack1, 1);
      checkOutput("bp_c1_sel", sel, 1);
      tick();
      applyStimulus(1'b0, 1'b1, 4'h0, 4'h9, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_c%0d_ack1", k), ack1, 0);
         checkOutput($sformatf("bp_c%0d_y", k), y, 4'h7);
         checkOutput($sformatf("bp_c%0d_owner", k), owner, 1);
         checkOutput($sformatf("bp_c%0d_y_valid", k), y_valid, 1);
         tick();
      end
      applyStimulus(1'b0, 1'b1, 4'h0, 4'h9, 1'b1);
      @(negedge clk);
      checkOutput("bp_resume_ack1", ack1, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h9, 1'b1);
      @(negedge clk);
      checkOutput("bp_resume_y", y, 4'h9);

      // Owner drops after two captures while the other side waits
      doReset();
      applyStimulus(1'b1, 1'b1, 4'h2, 4'h6, 1'b1);
      tick();
      @(negedge clk);
      checkOutput("drop_c1_ack0", ack0, 1);
      tick();
      @(negedge clk);
      checkOutput("drop_c2_ack0", ack0, 1);
      tick();
      applyStimulus(1'b0, 1'b1, 4'h2, 4'h6, 1'b1);
      @(negedge clk);
      checkOutput("drop_c3_ack0", ack0, 0);
      checkOutput("drop_c3_ack1", ack1, 0);
      checkOutput("drop_c3_sel", sel, 0);
      tick();
      for (int k = 4; k <= 8; k++) begin
         if (k == 6) applyStimulus(1'b1, 1'b1, 4'h2, 4'h6, 1'b1);
         @(negedge clk);
         checkOutput($sformatf("drop_c%0d_sel", k), sel, (k <= 7));
         checkOutput($sformatf("drop_c%0d_ack1", k), ack1, (k <= 7));
         checkOutput($sformatf("drop_c%0d_ack0", k), ack0, (k == 8));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 4'h2, 4'h6, 1'b1);

      // Long run on one side: burst limit must not cause gaps
      doReset();
      ack_count = 0;
      for (int k = 0; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1, 4'h0, (k == 0) ? 4'd1 : 4'(k), 1'b1);
         @(negedge clk);
         if (ack1) ack_count++;
         checkOutput($sformatf("burst_c%0d_ack1", k), ack1, (k >= 1));
         if (k >= 1) checkOutput($sformatf("burst_c%0d_sel", k), sel, 1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 4'h0, 4'hA, 1'b1);
      @(negedge clk);
      checkOutput("burst_ack_count", ack_count, 10);
      checkOutput("burst_last_y", y, 4'hA);
      checkOutput("burst_last_owner", owner, 1);

      // Reset asserted mid-transfer
      doReset();
      applyStimulus(1'b1, 1'b0, 4'hC, 4'h0, 1'b1);
      tick();
      tick();
      checkOutput("midrst_pre_y_valid", y_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_y_valid", y_valid, 0);
      checkOutput("midrst_y", y, 0);
      checkOutput("midrst_sel", sel, 0);
      checkOutput("midrst_owner", owner, 0);
      checkOutput("midrst_ack0", ack0, 0);
      checkOutput("midrst_ack1", ack1, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rel_ack0", ack0, 0);
      tick();
      @(negedge clk);
      checkOutput("midrst_retry_ack0", ack0, 1);
      checkOutput("midrst_retry_sel", sel, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'hC, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput("midrst_retry_y", y, 4'hC);
      checkOutput("midrst_retry_y_valid", y_valid, 1);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_arbiter.md
# operand_arbiter

- Arbitrates two operand requesters for one shared WIDTH-bit 2:1 operand mux and the signed-calculator datapath behind it.
- Drives the mux select line, captures the selected operand into an output register, and hands it downstream with a valid/ready handshake.
- Uses round-robin arbitration with a bounded burst length, so one requester cannot starve the other.

## Interface
Parameters:
- WIDTH, 4, operand width; matches the shared mux width.
- MAX_BURST, 4, maximum consecutive captures per grant when the other side is waiting; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0  in  1  requester 0 has an operand on i0; held high with i0 stable until ack0.
- req1  in  1  requester 1 has an operand on i1; held high with i1 stable until ack1.
- i0  in  WIDTH  operand from requester 0.
- i1  in  WIDTH  operand from requester 1.
- ack0  out  1  combinational; high in the cycle i0 is captured.
- ack1  out  1  combinational; high in the cycle i1 is captured.
- sel  out  1  registered mux select; 0 selects i0, 1 selects i1.
- y  out  WIDTH  registered captured operand.
- y_valid  out  1  y holds an operand not yet accepted downstream.
- y_ready  in  1  downstream accepts y when y_valid && y_ready.
- owner  out  1  requester index of the operand in y.

## Operation
- States:
  - IDLE: no grant.
  - OWN0: requester 0 granted; sel=0.
  - OWN1: requester 1 granted; sel=1.
- Registers: state, sel, y, y_valid, owner, 4-bit burst counter cnt, round-robin pointer rr (the side favoured on a tie).
- Reset values: state=IDLE, sel=0, y=0, y_valid=0, owner=0, cnt=0, rr=0. ack0 and ack1 are low during reset.
- IDLE transitions (evaluated each cycle):
  - Only req0 high → OWN0.
  - Only req1 high → OWN1.
  - Both high → OWN[rr].
  - Neither → stay IDLE.
  - sel keeps its last value while in IDLE.
- Capture in OWNx: occurs when reqx=1 and the slot is free (y_valid=0, or y_ready=1 in the same cycle). On capture:
  - ackx=1.
  - y←ix, owner←x, y_valid←1.
  - cnt←cnt+1.
- Downstream drain: if y_valid && y_ready and there is no capture that cycle, y_valid←0.
- Leaving OWNx, evaluated after the capture decision of the cycle:
  - reqx low, other req high → OWN(other), cnt←0, rr←other.
  - reqx low, other req low → IDLE, cnt←0.
  - Capture makes cnt reach MAX_BURST, other req high → OWN(other), cnt←0, rr←other.
  - Capture makes cnt reach MAX_BURST, other req low → stay OWNx, cnt←0.
  - Otherwise → stay OWNx.
- Arithmetic: cnt is 4-bit unsigned and never exceeds MAX_BURST; the compare uses the post-increment value.
- Only the granted side ever sees ack. The non-granted requester is never acked, whatever its req.

## Timing
- Grant latency: req rising in IDLE at cycle N → sel valid and first possible ack at N+1 → y_valid high at N+2.
- Throughput: one capture per cycle while the owner holds req and downstream keeps y_ready=1 (or the slot is empty).
- Backpressure: with y_valid=1 and y_ready=0, no ack is issued and y, owner and y_valid hold.
- Handover: the cycle after a switch, sel shows the new owner. The first capture for the new owner can happen in that same cycle, so there are no bubble cycles beyond the one-cycle re-grant.
- Simultaneous capture and drain: the new operand replaces the old one; y_valid stays 1.
- Reset asserted mid-transfer:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - A pending operand in y is discarded and not delivered.
  - Requesters must hold req and retry after reset is released.

## Test plan
- Reset check: rst=1 mid-burst → same cycle y_valid=0, y=0, sel=0, owner=0, ack0=ack1=0; after release with req0=1 → OWN0, ack0 one cycle later.
- Single requester:
  - Stimulus: req0=1, i0=4'h5, y_ready=1.
  - Required: sel=0 at N+1, ack0 at N+1, y=5, owner=0, y_valid=1 at N+2.
- Round-robin tie:
  - Stimulus: req0=req1=1 from IDLE after reset, MAX_BURST=4, y_ready=1.
  - Required: 4 acks on ack0, then sel=1 and 4 acks on ack1, then back to ack0; owner alternates in groups of 4.
- Backpressure:
  - Stimulus: in OWN1, y_ready=0 for 3 cycles.
  - Required: ack1 low, y and owner stable for those 3 cycles; capture resumes in the cycle y_ready=1.
- Owner drops:
  - Stimulus: OWN0 with req0 falling after 2 captures, req1=1.
  - Required: next cycle OWN1, sel=1, cnt restarts at 0.
- Burst limit, no contention:
  - Stimulus: req1 only, 10 operands.
  - Required: 10 consecutive acks with no gaps; state stays OWN1.
